// File: rtl/clock_time_keeper_pkg.sv
// Shared types and digit limits for the BCD time-of-day keeper.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_MSB_MAX       = 4'd5;
  localparam bcd_digit_t MIN_MSB_MAX       = 4'd5;
  localparam bcd_digit_t HOUR_MSB_MAX      = 4'd2;
  localparam bcd_digit_t HOUR_LSB_MAX_AT_2 = 4'd3;
  localparam bcd_digit_t BCD_MAX           = 4'd9;

  typedef enum logic [1:0] {
    RF_CLEAN,
    RF_DIRTY,
    RF_STROBE,
    RF_STROBE_DIRTY
  } refresh_state_t;

  // Upper digit limit of a two-digit counter: 23 for hours, 59 otherwise.
  function automatic bcd_digit_t msb_limit(int modulus, bit is_seconds);
    if (modulus == 24) return HOUR_MSB_MAX;
    return is_seconds ? SEC_MSB_MAX : MIN_MSB_MAX;
  endfunction

  function automatic bcd_digit_t lsb_limit_at_top(int modulus);
    return (modulus == 24) ? HOUR_LSB_MAX_AT_2 : BCD_MAX;
  endfunction

endpackage

// File: rtl/clock_time_keeper_if.sv
// Control and display bundle between the time keeper, its set buttons and the 7-segment output stage.
interface clock_time_keeper_if;
  import clock_pkg::*;

  logic       i_en;
  logic       i_inc_hours_stb;
  logic       i_inc_minutes_stb;
  logic       i_busy;
  logic       o_refresh_stb;
  bcd_digit_t o_hours_msb;
  bcd_digit_t o_hours_lsb;
  bcd_digit_t o_minutes_msb;
  bcd_digit_t o_minutes_lsb;
  bcd_digit_t o_seconds_msb;
  bcd_digit_t o_seconds_lsb;
  logic       o_dp_colon;
  logic       o_sec_stb;

  modport slave (
    input  i_en, i_inc_hours_stb, i_inc_minutes_stb, i_busy,
    output o_refresh_stb, o_hours_msb, o_hours_lsb, o_minutes_msb, o_minutes_lsb,
           o_seconds_msb, o_seconds_lsb, o_dp_colon, o_sec_stb
  );

  modport master (
    output i_en, i_inc_hours_stb, i_inc_minutes_stb, i_busy,
    input  o_refresh_stb, o_hours_msb, o_hours_lsb, o_minutes_msb, o_minutes_lsb,
           o_seconds_msb, o_seconds_lsb, o_dp_colon, o_sec_stb
  );
endinterface

// File: rtl/clock_time_keeper_bcd_pair_counter.sv
// Two-digit BCD modulo counter (MODULUS 60 or 24); carry is combinational on the wrapping increment.
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int MODULUS    = 60,
  parameter bit IS_SECONDS = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       inc,
  input  logic       clear,
  output bcd_digit_t msb,
  output bcd_digit_t lsb,
  output logic       carry
);

  localparam bcd_digit_t MSB_TOP = msb_limit(MODULUS, IS_SECONDS);
  localparam bcd_digit_t LSB_TOP = lsb_limit_at_top(MODULUS);

  logic at_top;

  assign at_top = (msb == MSB_TOP) && (lsb == LSB_TOP);
  assign carry  = inc && !clear && at_top;

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      msb <= '0;
      lsb <= '0;
    end else if (inc) begin
      if (at_top) begin
        msb <= '0;
        lsb <= '0;
      end else if (lsb == BCD_MAX) begin
        msb <= msb + 4'd1;
        lsb <= '0;
      end else begin
        lsb <= lsb + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// BCD time-of-day keeper: 1 Hz prescaler, hh:mm:ss counters, colon blink and refresh strobe handshake.
//   state           | meaning
//   RF_CLEAN        | display matches time, nothing pending
//   RF_DIRTY        | change pending, waiting for output stage idle
//   RF_STROBE       | refresh strobe high this cycle, nothing else pending
//   RF_STROBE_DIRTY | refresh strobe high, another change arrived meanwhile
module clock_time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  clock_time_keeper_if.slave   bus
);

  localparam int              PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   HALF_CNT = PW'(CLK_HZ / 2 - 1);
  localparam logic [PW-1:0]   TICK_CNT = PW'(CLK_HZ - 1);

  logic [PW-1:0]  presc;
  logic           half_evt, tick_evt, tick_apply, set_any, change;
  logic           dp_colon, sec_stb;
  logic           sec_carry, min_carry, hours_carry_unused;
  bcd_digit_t     h_msb, h_lsb, m_msb, m_lsb, s_msb, s_lsb;
  refresh_state_t state_q, state_d;
  logic           dirty_cur, stb_cur, fire, dirty_nxt;

  assign half_evt   = bus.i_en && (presc == HALF_CNT);
  assign tick_evt   = bus.i_en && (presc == TICK_CNT);
  assign set_any    = bus.i_inc_hours_stb || bus.i_inc_minutes_stb;
  // A set strobe steals the tick; the prescaler still wraps so the second stays 1 s long.
  assign tick_apply = tick_evt && !set_any;
  assign change     = half_evt || tick_evt || set_any;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc    <= '0;
      dp_colon <= 1'b1;
      sec_stb  <= 1'b0;
    end else begin
      sec_stb <= tick_apply;
      if (bus.i_inc_minutes_stb || tick_evt) begin
        presc    <= '0;
        dp_colon <= 1'b1;
      end else if (bus.i_en) begin
        presc <= presc + PW'(1);
        if (half_evt) dp_colon <= 1'b0;
      end
    end
  end

  bcd_pair_counter #(.MODULUS(60), .IS_SECONDS(1'b1)) u_seconds (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .inc    (tick_apply),
    .clear  (bus.i_inc_minutes_stb),
    .msb    (s_msb),
    .lsb    (s_lsb),
    .carry  (sec_carry)
  );

  bcd_pair_counter #(.MODULUS(60), .IS_SECONDS(1'b0)) u_minutes (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .inc    (sec_carry || bus.i_inc_minutes_stb),
    .clear  (1'b0),
    .msb    (m_msb),
    .lsb    (m_lsb),
    .carry  (min_carry)
  );

  // Manual minute set wraps 59->00 without touching hours.
  bcd_pair_counter #(.MODULUS(24), .IS_SECONDS(1'b0)) u_hours (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .inc    ((min_carry && !bus.i_inc_minutes_stb) || bus.i_inc_hours_stb),
    .clear  (1'b0),
    .msb    (h_msb),
    .lsb    (h_lsb),
    .carry  (hours_carry_unused)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= RF_DIRTY;
    else         state_q <= state_d;
  end

  always_comb begin
    dirty_cur = (state_q == RF_DIRTY) || (state_q == RF_STROBE_DIRTY);
    stb_cur   = (state_q == RF_STROBE) || (state_q == RF_STROBE_DIRTY);
    fire      = dirty_cur && !bus.i_busy && !stb_cur;
    dirty_nxt = change || (dirty_cur && !fire);
    state_d   = RF_CLEAN;
    case ({fire, dirty_nxt})
      2'b00:   state_d = RF_CLEAN;
      2'b01:   state_d = RF_DIRTY;
      2'b10:   state_d = RF_STROBE;
      default: state_d = RF_STROBE_DIRTY;
    endcase
  end

  assign bus.o_refresh_stb = stb_cur;
  assign bus.o_dp_colon    = dp_colon;
  assign bus.o_sec_stb     = sec_stb;
  assign bus.o_hours_msb   = h_msb;
  assign bus.o_hours_lsb   = h_lsb;
  assign bus.o_minutes_msb = m_msb;
  assign bus.o_minutes_lsb = m_lsb;
  assign bus.o_seconds_msb = s_msb;
  assign bus.o_seconds_lsb = s_lsb;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Scoreboard bench for clock_time_keeper at CLK_HZ=10: expected refresh/second strobes are queued with their cycle.
module tb_clock_time_keeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_time_keeper_if bus();

  clock_time_keeper #(.CLK_HZ(10)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    int          cyc;
    logic [23:0] t;
    logic        colon;
  } exp_t;

  exp_t rq[$];
  int   sq[$];
  bit   chk_on = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [23:0] now_t();
    return {bus.o_hours_msb, bus.o_hours_lsb, bus.o_minutes_msb, bus.o_minutes_lsb,
            bus.o_seconds_msb, bus.o_seconds_lsb};
  endfunction

  function automatic logic [7:0] bcd8(int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void push_r(int c, logic [23:0] t, logic col);
    exp_t e;
    e.cyc = c;
    e.t = t;
    e.colon = col;
    rq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && chk_on) begin
      if (bus.o_refresh_stb) begin
        if (rq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL refresh_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          e = rq.pop_front();
          check("refresh_cycle", cyc, e.cyc);
          check("refresh_time", now_t(), e.t);
          check("refresh_colon", bus.o_dp_colon, e.colon);
        end
      end
      if (bus.o_sec_stb) begin
        if (sq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sec_stb_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          check("sec_stb_cycle", cyc, sq.pop_front());
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(bit en, bit busy);
    rst = 1'b1;
    bus.i_en = en;
    bus.i_busy = busy;
    bus.i_inc_hours_stb = 1'b0;
    bus.i_inc_minutes_stb = 1'b0;
    step(2);
    check("reset_time", now_t(), 24'h000000);
    check("reset_colon", bus.o_dp_colon, 1'b1);
    check("reset_refresh", bus.o_refresh_stb, 1'b0);
    check("reset_sec_stb", bus.o_sec_stb, 1'b0);
    rst = 1'b0;
  endtask

  task automatic end_phase();
    check("refresh_left", rq.size(), 0);
    check("sec_stb_left", sq.size(), 0);
    chk_on = 1'b0;
    rq.delete();
    sq.delete();
  endtask

  task automatic strobe_h(int n);
    for (int i = 0; i < n; i++) begin
      bus.i_inc_hours_stb = 1'b1;
      step(1);
      bus.i_inc_hours_stb = 1'b0;
      step(1);
    end
  endtask

  task automatic strobe_m(int n);
    for (int i = 0; i < n; i++) begin
      bus.i_inc_minutes_stb = 1'b1;
      step(1);
      bus.i_inc_minutes_stb = 1'b0;
      step(1);
    end
  endtask

  initial begin
    int k;
    bus.i_en = 1'b0;
    bus.i_busy = 1'b0;
    bus.i_inc_hours_stb = 1'b0;
    bus.i_inc_minutes_stb = 1'b0;

    // first refresh, half-second colon, first tick
    do_reset(1'b1, 1'b0);
    chk_on = 1'b1;
    push_r(1, 24'h000000, 1'b1);
    push_r(6, 24'h000000, 1'b0);
    push_r(11, 24'h000001, 1'b1);
    sq.push_back(10);
    step(10);
    check("tick_time", now_t(), 24'h000001);
    check("tick_colon", bus.o_dp_colon, 1'b1);
    step(2);
    end_phase();

    // busy held over half event and tick, then one coalesced refresh
    do_reset(1'b1, 1'b1);
    chk_on = 1'b1;
    push_r(13, 24'h000001, 1'b1);
    push_r(16, 24'h000001, 1'b0);
    sq.push_back(10);
    step(12);
    check("busy_time_moves", now_t(), 24'h000001);
    bus.i_busy = 1'b0;
    step(5);
    end_phase();

    // freeze with i_en=0, set strobes while frozen, hours 23->00, both strobes at once
    do_reset(1'b1, 1'b0);
    chk_on = 1'b1;
    push_r(1, 24'h000000, 1'b1);
    push_r(6, 24'h000000, 1'b0);
    step(7);
    bus.i_en = 1'b0;
    step(30);
    check("freeze_time", now_t(), 24'h000000);
    check("freeze_colon", bus.o_dp_colon, 1'b0);
    push_r(cyc + 2, 24'h000100, 1'b1);
    strobe_m(1);
    for (int n = 0; n < 24; n++) begin
      push_r(cyc + 2, {bcd8((n + 1) % 24), 8'h01, 8'h00}, 1'b1);
      strobe_h(1);
    end
    check("hours_wrap", now_t(), 24'h000100);
    k = cyc;
    bus.i_en = 1'b1;
    push_r(k + 6, 24'h000100, 1'b0);
    sq.push_back(k + 10);
    push_r(k + 11, 24'h000101, 1'b1);
    step(12);
    push_r(k + 14, 24'h010200, 1'b1);
    push_r(k + 19, 24'h010200, 1'b0);
    bus.i_inc_hours_stb = 1'b1;
    bus.i_inc_minutes_stb = 1'b1;
    step(1);
    bus.i_inc_hours_stb = 1'b0;
    bus.i_inc_minutes_stb = 1'b0;
    step(7);
    end_phase();

    // preload 23:59:59 then roll over to 00:00:00
    do_reset(1'b0, 1'b0);
    strobe_h(23);
    strobe_m(59);
    k = cyc;
    bus.i_en = 1'b1;
    step(597);
    check("preload_time", now_t(), 24'h235959);
    check("preload_colon", bus.o_dp_colon, 1'b0);
    chk_on = 1'b1;
    sq.push_back(k + 600);
    push_r(k + 601, 24'h000000, 1'b1);
    push_r(k + 606, 24'h000000, 1'b0);
    step(11);
    end_phase();

    // minute set coincident with tick at 12:59:37
    do_reset(1'b0, 1'b0);
    strobe_h(12);
    strobe_m(59);
    k = cyc;
    bus.i_en = 1'b1;
    step(379);
    check("pre_set_time", now_t(), 24'h125937);
    chk_on = 1'b1;
    push_r(k + 381, 24'h120000, 1'b1);
    push_r(k + 386, 24'h120000, 1'b0);
    sq.push_back(k + 390);
    push_r(k + 391, 24'h120001, 1'b1);
    bus.i_inc_minutes_stb = 1'b1;
    step(1);
    bus.i_inc_minutes_stb = 1'b0;
    check("set_on_tick_time", now_t(), 24'h120000);
    step(12);
    end_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
